// File: rtl/ascon_pack.sv
// Shared types for the ASCON block sequencer: 64-bit block, padding block, FIFO entry.
// The padding path is only built when BLOC_SEQ_PAD_EN is defined.
package ascon_pack;

    typedef logic [63:0] bloc_t;

    localparam bloc_t PAD_BLOC = 64'h8000_0000_0000_0000;

    // One buffered block together with its end-of-message marker.
    typedef struct packed {
        logic  last;
        bloc_t data;
    } entree_t;

endpackage

// File: rtl/bloc_sequenceur_if.sv
// Host-loader / permutation-FSM bus of the block sequencer. The slave modport is the sequencer view.
// wr_nbytes_i only exists when BLOC_SEQ_PAD_EN is defined.
interface bloc_sequenceur_if
    import ascon_pack::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_valid_i;
    bloc_t             wr_data_i;
    logic              wr_last_i;
    logic              wr_ready_o;
`ifdef BLOC_SEQ_PAD_EN
    logic [3:0]        wr_nbytes_i;
`endif
    logic              rd_valid_o;
    bloc_t             rd_data_o;
    logic              rd_last_o;
    logic [IDX_W-1:0]  rd_idx_o;
    logic              rd_ready_i;
    logic [CNT_W-1:0]  count_o;

`ifdef BLOC_SEQ_PAD_EN
    modport slave (
        input  wr_valid_i, wr_data_i, wr_last_i, wr_nbytes_i, rd_ready_i,
        output wr_ready_o, rd_valid_o, rd_data_o, rd_last_o, rd_idx_o, count_o
    );

    modport master (
        output wr_valid_i, wr_data_i, wr_last_i, wr_nbytes_i, rd_ready_i,
        input  wr_ready_o, rd_valid_o, rd_data_o, rd_last_o, rd_idx_o, count_o
    );
`else
    modport slave (
        input  wr_valid_i, wr_data_i, wr_last_i, rd_ready_i,
        output wr_ready_o, rd_valid_o, rd_data_o, rd_last_o, rd_idx_o, count_o
    );

    modport master (
        output wr_valid_i, wr_data_i, wr_last_i, rd_ready_i,
        input  wr_ready_o, rd_valid_o, rd_data_o, rd_last_o, rd_idx_o, count_o
    );
`endif

endinterface

// File: rtl/bloc_pad.sv
// Combinational ASCON padding of a final block: bytes below nbytes kept, 0x80 at nbytes, zeros above.
// Only compiled when BLOC_SEQ_PAD_EN is defined; nbytes >= 8 leaves the block untouched.
`ifdef BLOC_SEQ_PAD_EN
module bloc_pad
    import ascon_pack::*;
(
    input  logic [3:0] nbytes_i,
    input  bloc_t      bloc_i,
    output bloc_t      bloc_o
);

    // Byte gi occupies bits 63-8*gi downto 56-8*gi (big-endian numbering).
    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_octet
        localparam logic [3:0] RANG = 4'(gi);
        assign bloc_o[63-8*gi -: 8] = (RANG < nbytes_i)  ? bloc_i[63-8*gi -: 8] :
                                      (RANG == nbytes_i) ? 8'h80 : 8'h00;
    end

endmodule
`endif

// File: rtl/bloc_sequenceur.sv
// Block FIFO between host loader and ASCON permutation FSM, tagging blocks with index and last flag.
// Define BLOC_SEQ_PAD_EN to pad the final block and emit the extra PAD_BLOC after a full final block.
module bloc_sequenceur
    import ascon_pack::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
)
(
    input  logic clock_i,
    input  logic resetb_i,
    input  logic init_i,
    bloc_sequenceur_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    entree_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pad_pending_q, pad_pending_d;

    logic             push;
    logic             pop;
    logic             pop_stocke;
    logic             pad_tete;
    logic             pad_arme;
    entree_t          entree_ecrite;
    entree_t          entree_lue;

`ifdef BLOC_SEQ_PAD_EN
    bloc_t bloc_padde;
    logic  nbytes_plein;

    bloc_pad u_bloc_pad (
        .nbytes_i (bus.wr_nbytes_i),
        .bloc_i   (bus.wr_data_i),
        .bloc_o   (bloc_padde)
    );

    // A full final block carries no padding room, so the pad block follows it separately.
    assign nbytes_plein = bus.wr_last_i & (bus.wr_nbytes_i >= 4'd8);

    always_comb begin
        entree_ecrite.data = bus.wr_last_i ? bloc_padde : bus.wr_data_i;
        entree_ecrite.last = bus.wr_last_i & ~nbytes_plein;
    end

    assign pad_arme = push & nbytes_plein;
`else
    always_comb begin
        entree_ecrite.data = bus.wr_data_i;
        entree_ecrite.last = bus.wr_last_i;
    end

    assign pad_arme = 1'b0;
`endif

    // The pad block is only at the head once every stored block has drained.
    assign pad_tete   = (count_q == '0) & pad_pending_q;
    assign entree_lue = mem_q[rd_ptr_q];

    assign bus.wr_ready_o = (count_q != CNT_FULL) & ~pad_pending_q;
    assign bus.rd_valid_o = (count_q != '0) | pad_pending_q;
    assign bus.rd_data_o  = pad_tete ? PAD_BLOC : entree_lue.data;
    assign bus.rd_last_o  = pad_tete | entree_lue.last;
    assign bus.rd_idx_o   = idx_q;
    assign bus.count_o    = count_q;

    assign push       = bus.wr_valid_i & bus.wr_ready_o;
    assign pop        = bus.rd_valid_o & bus.rd_ready_i;
    assign pop_stocke = pop & (count_q != '0);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        idx_d         = idx_q;
        pad_pending_d = pad_pending_q;

        if (init_i) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            idx_d         = '0;
            pad_pending_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_stocke) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({push, pop_stocke})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            if (pop) begin
                idx_d = bus.rd_last_o ? '0 : idx_q + IDX_W'(1);
            end

            if (pad_arme) begin
                pad_pending_d = 1'b1;
            end else if (pop & pad_tete) begin
                pad_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            pad_pending_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            pad_pending_q <= pad_pending_d;
        end
    end

    // Storage carries no reset: the pointers and count alone define what is valid.
    always_ff @(posedge clock_i) begin
        if (push & ~init_i) begin
            mem_q[wr_ptr_q] <= entree_ecrite;
        end
    end

endmodule

// File: tb/tb_bloc_sequenceur.sv
// Directed bench for bloc_sequenceur: vector table plus hand sequences (async reset, padding).
// Padding checks are compiled only when BLOC_SEQ_PAD_EN is defined.
module tb_bloc_sequenceur;
    import ascon_pack::*;

    localparam int DEPTH = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 3;

    logic clock_i  = 1'b0;
    logic resetb_i = 1'b0;
    logic init_i   = 1'b0;

    always #5 clock_i = ~clock_i;

    bloc_sequenceur_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

    bloc_sequenceur #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .init_i   (init_i),
        .bus      (bus)
    );

    typedef struct {
        logic             wv;
        bloc_t            wd;
        logic             wl;
        logic             rr;
        logic             ini;
        logic             e_wr_ready;
        logic             e_rv;
        bloc_t            e_data;
        logic             e_last;
        logic [IDX_W-1:0] e_idx;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam bloc_t BA = 64'h0123_4567_89AB_CDEF;
    localparam bloc_t BB = 64'hFEDC_BA98_7654_3210;
    localparam bloc_t BC = 64'h1111_2222_3333_4444;

    function automatic bloc_t blk(input logic [7:0] tag, input int k);
        return {tag, 48'h0000_5A5A_0000, 8'(k)};
    endfunction

    function automatic vec_t mk(input logic wv, input bloc_t wd, input logic wl,
                                input logic rr, input logic ini,
                                input logic ewr, input logic erv, input bloc_t ed,
                                input logic el, input int eidx, input int ecnt);
        vec_t v;
        v.wv = wv; v.wd = wd; v.wl = wl; v.rr = rr; v.ini = ini;
        v.e_wr_ready = ewr; v.e_rv = erv; v.e_data = ed; v.e_last = el;
        v.e_idx = IDX_W'(eidx);
        v.e_cnt = CNT_W'(ecnt);
        return v;
    endfunction

    task automatic chk(input string nom, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nom, got, exp);
        end
    endtask

    task automatic drive(input logic wv, input bloc_t wd, input logic wl,
                         input logic rr, input logic ini);
        bus.wr_valid_i = wv;
        bus.wr_data_i  = wd;
        bus.wr_last_i  = wl;
        bus.rd_ready_i = rr;
        init_i         = ini;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef BLOC_SEQ_PAD_EN
        bus.wr_nbytes_i = 4'd0;
`endif

        // Test 1: A, B, C(last) streamed with the consumer always ready.
        vecs.push_back(mk(1, BA, 0, 1, 0,  1, 0, '0, 0, 0, 0));
        vecs.push_back(mk(1, BB, 0, 1, 0,  1, 1, BA, 0, 0, 1));
        vecs.push_back(mk(1, BC, 1, 1, 0,  1, 1, BB, 0, 1, 1));
        vecs.push_back(mk(0, '0, 0, 1, 0,  1, 1, BC, 1, 2, 1));
        vecs.push_back(mk(0, '0, 0, 0, 0,  1, 0, '0, 0, 0, 0));
        // Test 2/3: fill to full, stall, push+pop while full, 5th accepted after one pop.
        vecs.push_back(mk(1, blk(8'hD0, 0), 0, 0, 0,  1, 0, '0, 0, 0, 0));
        vecs.push_back(mk(1, blk(8'hD0, 1), 0, 0, 0,  1, 1, blk(8'hD0, 0), 0, 0, 1));
        vecs.push_back(mk(1, blk(8'hD0, 2), 0, 0, 0,  1, 1, blk(8'hD0, 0), 0, 0, 2));
        vecs.push_back(mk(1, blk(8'hD0, 3), 0, 0, 0,  1, 1, blk(8'hD0, 0), 0, 0, 3));
        vecs.push_back(mk(1, blk(8'hD0, 4), 0, 0, 0,  0, 1, blk(8'hD0, 0), 0, 0, 4));
        vecs.push_back(mk(1, blk(8'hD0, 4), 0, 1, 0,  0, 1, blk(8'hD0, 0), 0, 0, 4));
        vecs.push_back(mk(1, blk(8'hD0, 4), 0, 0, 0,  1, 1, blk(8'hD0, 1), 0, 1, 3));
        vecs.push_back(mk(0, '0, 0, 0, 0,  0, 1, blk(8'hD0, 1), 0, 1, 4));
        vecs.push_back(mk(0, '0, 0, 1, 0,  0, 1, blk(8'hD0, 1), 0, 1, 4));
        vecs.push_back(mk(0, '0, 0, 1, 0,  1, 1, blk(8'hD0, 2), 0, 2, 3));
        vecs.push_back(mk(0, '0, 0, 1, 0,  1, 1, blk(8'hD0, 3), 0, 3, 2));
        vecs.push_back(mk(0, '0, 0, 1, 0,  1, 1, blk(8'hD0, 4), 0, 0, 1));
        // Empty with rd_ready high: nothing pops, index stays.
        vecs.push_back(mk(0, '0, 0, 1, 0,  1, 0, '0, 0, 1, 0));
        vecs.push_back(mk(0, '0, 0, 0, 1,  1, 0, '0, 0, 1, 0));
        vecs.push_back(mk(0, '0, 0, 0, 0,  1, 0, '0, 0, 0, 0));
        // Test 4: six-block message, index 0,1,2,3,0,1, then init mid-stream.
        vecs.push_back(mk(1, blk(8'hE0, 0), 0, 1, 0,  1, 0, '0, 0, 0, 0));
        vecs.push_back(mk(1, blk(8'hE0, 1), 0, 1, 0,  1, 1, blk(8'hE0, 0), 0, 0, 1));
        vecs.push_back(mk(1, blk(8'hE0, 2), 0, 1, 0,  1, 1, blk(8'hE0, 1), 0, 1, 1));
        vecs.push_back(mk(1, blk(8'hE0, 3), 0, 1, 0,  1, 1, blk(8'hE0, 2), 0, 2, 1));
        vecs.push_back(mk(1, blk(8'hE0, 4), 0, 1, 0,  1, 1, blk(8'hE0, 3), 0, 3, 1));
        vecs.push_back(mk(1, blk(8'hE0, 5), 1, 1, 0,  1, 1, blk(8'hE0, 4), 0, 0, 1));
        vecs.push_back(mk(1, blk(8'hF0, 0), 0, 1, 0,  1, 1, blk(8'hE0, 5), 1, 1, 1));
        vecs.push_back(mk(1, blk(8'hF0, 1), 0, 1, 0,  1, 1, blk(8'hF0, 0), 0, 0, 1));
        vecs.push_back(mk(1, blk(8'hF0, 2), 0, 1, 1,  1, 1, blk(8'hF0, 1), 0, 1, 1));
        vecs.push_back(mk(1, blk(8'hC0, 0), 0, 0, 0,  1, 0, '0, 0, 0, 0));
        vecs.push_back(mk(1, blk(8'hC0, 1), 0, 1, 0,  1, 1, blk(8'hC0, 0), 0, 0, 1));
        vecs.push_back(mk(1, blk(8'hC0, 2), 0, 0, 0,  1, 1, blk(8'hC0, 1), 0, 1, 1));
        vecs.push_back(mk(0, '0, 0, 0, 0,  1, 1, blk(8'hC0, 1), 0, 1, 2));

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        chk("reset_rv", 64'(bus.rd_valid_o), 64'd0);
        chk("reset_cnt", 64'(bus.count_o), 64'd0);
        chk("reset_idx", 64'(bus.rd_idx_o), 64'd0);
        resetb_i = 1'b1;
        #1;
        chk("release_wr_ready", 64'(bus.wr_ready_o), 64'd1);
        @(posedge clock_i);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].wv, vecs[i].wd, vecs[i].wl, vecs[i].rr, vecs[i].ini);
            @(negedge clock_i);
            $display("vec %0d wv=%b wd=%h rr=%b ini=%b : wr_ready=%b rv=%b data=%h last=%b idx=%0d cnt=%0d",
                     i, vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].ini, bus.wr_ready_o,
                     bus.rd_valid_o, bus.rd_data_o, bus.rd_last_o, bus.rd_idx_o, bus.count_o);
            chk($sformatf("v%0d_wr_ready", i), 64'(bus.wr_ready_o), 64'(vecs[i].e_wr_ready));
            chk($sformatf("v%0d_rv", i), 64'(bus.rd_valid_o), 64'(vecs[i].e_rv));
            chk($sformatf("v%0d_cnt", i), 64'(bus.count_o), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_idx", i), 64'(bus.rd_idx_o), 64'(vecs[i].e_idx));
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_data", i), bus.rd_data_o, vecs[i].e_data);
                chk($sformatf("v%0d_last", i), 64'(bus.rd_last_o), 64'(vecs[i].e_last));
            end
            @(posedge clock_i);
            #1;
        end

        // Test 5: asynchronous reset pulse mid-cycle with two blocks stored.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("pre_areset_cnt", 64'(bus.count_o), 64'd2);
        #3;
        resetb_i = 1'b0;
        #1;
        $display("areset asserted mid-cycle : rv=%b idx=%0d cnt=%0d", bus.rd_valid_o, bus.rd_idx_o, bus.count_o);
        chk("areset_rv", 64'(bus.rd_valid_o), 64'd0);
        chk("areset_cnt", 64'(bus.count_o), 64'd0);
        chk("areset_idx", 64'(bus.rd_idx_o), 64'd0);
        #2;
        resetb_i = 1'b1;
        #1;
        chk("areset_release_wr_ready", 64'(bus.wr_ready_o), 64'd1);
        @(posedge clock_i);
        #1;
        chk("areset_after_edge_rv", 64'(bus.rd_valid_o), 64'd0);
        chk("areset_after_edge_cnt", 64'(bus.count_o), 64'd0);

`ifdef BLOC_SEQ_PAD_EN
        // Test 6a: final block with 3 valid bytes is padded in place.
        drive(1'b1, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b0);
        bus.wr_nbytes_i = 4'd3;
        @(posedge clock_i);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clock_i);
        $display("pad nbytes=3 : rv=%b data=%h last=%b", bus.rd_valid_o, bus.rd_data_o, bus.rd_last_o);
        chk("pad3_data", bus.rd_data_o, 64'h1122_3380_0000_0000);
        chk("pad3_last", 64'(bus.rd_last_o), 64'd1);
        chk("pad3_cnt", 64'(bus.count_o), 64'd1);
        bus.rd_ready_i = 1'b1;
        @(posedge clock_i);
        #1;
        bus.rd_ready_i = 1'b0;
        // Test 6b: nbytes ignored on a non-final block.
        drive(1'b1, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b0);
        bus.wr_nbytes_i = 4'd2;
        @(posedge clock_i);
        #1;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clock_i);
        $display("pad non-last : data=%h last=%b", bus.rd_data_o, bus.rd_last_o);
        chk("nolast_data", bus.rd_data_o, 64'h1122_3344_5566_7788);
        chk("nolast_last", 64'(bus.rd_last_o), 64'd0);
        @(posedge clock_i);
        #1;
        // Test 6c: full final block, then the separate pad block carrying last.
        drive(1'b1, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b0);
        bus.wr_nbytes_i = 4'd8;
        @(posedge clock_i);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clock_i);
        $display("pad nbytes=8 : data=%h last=%b wr_ready=%b", bus.rd_data_o, bus.rd_last_o, bus.wr_ready_o);
        chk("pad8_data", bus.rd_data_o, 64'h1122_3344_5566_7788);
        chk("pad8_last", 64'(bus.rd_last_o), 64'd0);
        chk("pad8_wr_ready", 64'(bus.wr_ready_o), 64'd0);
        bus.rd_ready_i = 1'b1;
        @(posedge clock_i);
        #1;
        @(negedge clock_i);
        $display("pad block : rv=%b data=%h last=%b idx=%0d cnt=%0d", bus.rd_valid_o, bus.rd_data_o,
                 bus.rd_last_o, bus.rd_idx_o, bus.count_o);
        chk("padblk_rv", 64'(bus.rd_valid_o), 64'd1);
        chk("padblk_data", bus.rd_data_o, PAD_BLOC);
        chk("padblk_last", 64'(bus.rd_last_o), 64'd1);
        chk("padblk_cnt", 64'(bus.count_o), 64'd0);
        chk("padblk_wr_ready", 64'(bus.wr_ready_o), 64'd0);
        chk("padblk_idx", 64'(bus.rd_idx_o), 64'd2);
        @(posedge clock_i);
        #1;
        bus.rd_ready_i = 1'b0;
        @(negedge clock_i);
        chk("padend_rv", 64'(bus.rd_valid_o), 64'd0);
        chk("padend_wr_ready", 64'(bus.wr_ready_o), 64'd1);
        chk("padend_idx", 64'(bus.rd_idx_o), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
